ram_dp_param: RTL and testbench
===============================

Name: ram_dp_param

Overview:
Parametrised simple dual-port RAM, the successor to the fixed dual-port RAM. It has one write port and one read port on one clock. It adds byte-enable writes, a configurable read latency, a selectable read/write collision policy, and out-of-range error flags. A post-reset init sequencer zeroes the whole array before any access is accepted.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 4, address width.
- DEPTH, 16, number of words; DEPTH <= 2**ADDR_W.
- RD_LAT, 1, read latency in cycles; legal values are 1 or 2.
- COLLISION, 0, same-address collision policy: 0 = READ_FIRST, 1 = WRITE_FIRST.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_enb  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i]
- rd_enb  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data is valid this cycle
- wr_err  out  1  one-cycle pulse: write to an address >= DEPTH
- rd_err  out  1  out-of-range read flag, aligned with rd_valid
- init_busy  out  1  init sequence active; all requests are ignored

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - While rst=1: rd_data=0, rd_valid=0, wr_err=0, rd_err=0, init_busy=1, the read pipeline is flushed, and the init counter is held at 0.
- Init FSM, states ST_INIT and ST_READY:
  - ST_INIT: on each edge with rst=0, write 0 to word[cnt] and increment cnt.
  - After writing DEPTH-1, go to ST_READY. init_busy=0 from the following cycle.
  - init_busy is therefore high for exactly DEPTH cycles after rst falls.
  - In ST_INIT, wr_enb and rd_enb are ignored: no write, no rd_valid, no errors.
- Write, in ST_READY:
  - If wr_enb=1 and wr_addr<DEPTH: at the clock edge, update only the bytes with wr_be set.
  - wr_be=0 is a legal no-op.
  - If wr_addr>=DEPTH: memory is unchanged and wr_err=1 for exactly the next cycle.
- Read, in ST_READY:
  - A request with rd_enb=1 gives rd_valid=1 exactly RD_LAT cycles later, with rd_data for the address sampled at request time.
  - Throughput is one read per cycle; back-to-back reads produce consecutive rd_valid cycles in request order.
  - rd_addr>=DEPTH: rd_valid=1, rd_data=0 and rd_err=1, all in the same cycle.
  - rd_data holds its last value while rd_valid=0.
- Collision (same valid address, wr_enb and rd_enb in the same cycle):
  - READ_FIRST returns the pre-write word.
  - WRITE_FIRST returns the merged word: new bytes where wr_be=1, old bytes elsewhere.
  - The write completes in both modes.
- RD_LAT=2: a write that lands in the slot between request and response does not alter the in-flight data.
- Reset mid-operation:
  - In-flight reads are discarded; rd_valid=0 from the cycle after rst is sampled.
  - On rst release, init restarts from address 0.
- Addresses wider than needed are compared against DEPTH, never truncated.

Decomposition:
- Package ram_pkg:
  - enum collision_e {READ_FIRST, WRITE_FIRST}
  - enum init_state_e {ST_INIT, ST_READY}
  - function byte_merge(old, new, be) returning a DATA_W-bit word
- Sub-module ram_init_ctrl:
  - Contains the init FSM and counter.
  - Outputs: init_busy, init_we, init_addr.
  - The top muxes init_we/init_addr/0 onto the array write port during ST_INIT.

Test Plan:
- Init: DEPTH=16; rst high 2 cycles, then low. Expect init_busy high for exactly 16 cycles. Then read addresses 0..15 and expect all rd_data=0, rd_err=0.
- Byte-enable merge:
  - Write 0xAABBCCDD to addr 3 with be=4'b1111.
  - Then write 0x11223344 to addr 3 with be=4'b0101.
  - Read addr 3: expect 0xAA22CC44 after RD_LAT cycles.
- Collision: addr 5 = 0. In the same cycle, write 0xDEADBEEF (be=1111) and read addr 5.
  - COLLISION=0 returns 0x00000000; COLLISION=1 returns 0xDEADBEEF.
  - A following read of addr 5 returns 0xDEADBEEF in both modes.
- Range errors: DEPTH=12, ADDR_W=4.
  - Write addr 13: expect one wr_err pulse and addresses 0..11 unchanged.
  - Read addr 14: expect rd_valid=1, rd_err=1, rd_data=0.
- Streaming: RD_LAT=2, addr i preloaded with i+0x100. Read addrs 0..7 on consecutive cycles. Expect rd_valid high for 8 consecutive cycles starting 2 cycles after the first request, with data 0x100..0x107 in order.
- Reset mid-stream: assert rst with 2 reads in flight. Expect rd_valid=0 on the next cycle and init_busy=1. After re-init, a previously written address reads 0.

Source files
------------

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_pkg
// Purpose  : Shared types and helpers for the parametrised dual-port RAM.
//            - collision_e  : same-address read/write policy
//            - init_state_e : post-reset init sequencer states
//            - byte_merge() : byte-enable merge of a new word into an old one
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ram_pkg;

    typedef enum logic [0:0] {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } collision_e;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } init_state_e;

    // Widest data word the merge helper handles. Callers zero-extend their
    // operands to this width and truncate the result back to DATA_W; the
    // unused upper lanes are constant and disappear in synthesis.
    localparam int unsigned c_max_data_w = 1024;
    localparam int unsigned c_max_be_w   = c_max_data_w / 8;

    // Returns old_word with every byte lane whose enable bit is set replaced
    // by the corresponding lane of new_word.
    function automatic logic [c_max_data_w-1:0] byte_merge(
        input logic [c_max_data_w-1:0] old_word,
        input logic [c_max_data_w-1:0] new_word,
        input logic [c_max_be_w-1:0]   be
    );
        logic [c_max_data_w-1:0] merged;
        merged = old_word;
        for (int i = 0; i < int'(c_max_be_w); i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_init_ctrl
// Purpose  : Post-reset init sequencer. After reset releases it walks the
//            address space 0..DEPTH-1, one word per cycle, asking the array to
//            write zero, then parks in ST_READY until the next reset.
// Ports    : clk        in   clock
//            rst        in   synchronous active-high reset
//            init_busy  out  sequencer active (array closed to users)
//            init_we    out  write-zero strobe for the array
//            init_addr  out  address being cleared
// Revision : 1.0 - initial release
// ============================================================================
module ram_init_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_busy,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr
);
    import ram_pkg::*;

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    init_state_e       r_state;
    init_state_e       w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_INIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_last_addr) begin
                    w_state_nxt = ST_READY;
                    w_cnt_nxt   = '0;
                end
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic. The write strobe is masked during reset so the array is
    // only touched on edges that actually advance the sequencer.
    always_comb begin
        init_busy = (r_state == ST_INIT);
        init_we   = (r_state == ST_INIT) && !rst;
        init_addr = r_cnt;
    end

endmodule : ram_init_ctrl
`default_nettype wire

// File: rtl/ram_dp_param.sv
`default_nettype none
// ============================================================================
// Module   : ram_dp_param
// Purpose  : Parametrised simple dual-port RAM (one write port, one read port,
//            single clock) with byte-enable writes, 1- or 2-cycle read latency,
//            selectable same-address collision policy, out-of-range error
//            flags and a post-reset zeroing sequence.
// Ports    : clk        in   clock
//            rst        in   synchronous active-high reset
//            wr_enb     in   write request
//            wr_addr    in   write address
//            wr_data    in   write data
//            wr_be      in   byte enables, bit i covers wr_data[8i+7:8i]
//            rd_enb     in   read request
//            rd_addr    in   read address
//            rd_data    out  read data (held while rd_valid is low)
//            rd_valid   out  rd_data valid, RD_LAT cycles after the request
//            wr_err     out  one-cycle pulse after a write to addr >= DEPTH
//            rd_err     out  out-of-range read, aligned with rd_valid
//            init_busy  out  zeroing sequence active, requests ignored
// Revision : 1.0 - initial release
// ============================================================================
module ram_dp_param #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int DEPTH     = 16,
    parameter int RD_LAT    = 1,
    parameter int COLLISION = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_enb,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_enb,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                wr_err,
    output logic                rd_err,
    output logic                init_busy
);
    import ram_pkg::*;

    // One extra bit so DEPTH == 2**ADDR_W is representable and the range
    // check compares the full address instead of a truncated one.
    localparam logic [ADDR_W:0] c_depth  = (ADDR_W + 1)'(DEPTH);
    localparam collision_e      c_policy = (COLLISION != 0) ? WRITE_FIRST : READ_FIRST;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_init_busy;
    logic              w_init_we;
    logic [ADDR_W-1:0] w_init_addr;

    logic              w_ready;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_wr_go;
    logic              w_wr_bad;
    logic              w_rd_go;
    logic              w_rd_bad;
    logic [DATA_W-1:0] w_old_word;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_rd_word;

    logic              r_wr_err;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_rd_err;

    ram_init_ctrl #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_init_ctrl (
        .clk       (clk),
        .rst       (rst),
        .init_busy (w_init_busy),
        .init_we   (w_init_we),
        .init_addr (w_init_addr)
    );

    // ------------------------------------------------------------------
    // Request qualification. Nothing is accepted while reset is asserted
    // or while the zeroing sequence still owns the array.
    // ------------------------------------------------------------------
    always_comb begin
        w_ready       = !w_init_busy && !rst;
        w_wr_in_range = ({1'b0, wr_addr} < c_depth);
        w_rd_in_range = ({1'b0, rd_addr} < c_depth);
        w_wr_go       = w_ready && wr_enb && w_wr_in_range;
        w_wr_bad      = w_ready && wr_enb && !w_wr_in_range;
        w_rd_go       = w_ready && rd_enb;
        w_rd_bad      = w_ready && rd_enb && !w_rd_in_range;
    end

    // Word after applying the byte enables to the current contents.
    always_comb begin
        w_old_word = w_wr_in_range ? r_mem[wr_addr] : '0;
        w_merged   = DATA_W'(byte_merge(c_max_data_w'(w_old_word),
                                        c_max_data_w'(wr_data),
                                        c_max_be_w'(wr_be)));
    end

    // Word captured for a read this cycle. Out-of-range reads return zero.
    // Under WRITE_FIRST a same-cycle write to the same address is forwarded;
    // under READ_FIRST the array still holds the pre-write word at this point.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            if ((c_policy == WRITE_FIRST) && w_wr_go && (wr_addr == rd_addr)) begin
                w_rd_word = w_merged;
            end else begin
                w_rd_word = r_mem[rd_addr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Array write port: the init sequencer and the user port are never
    // active together, the sequencer simply wins the mux.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_init_we) begin
            r_mem[w_init_addr] <= '0;
        end else if (w_wr_go) begin
            r_mem[wr_addr] <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_wr_bad;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. Data is captured at request time, so a write landing
    // between request and response never alters an in-flight word.
    // ------------------------------------------------------------------
    if (RD_LAT == 2) begin : g_lat2
        logic              r_s1_valid;
        logic              r_s1_err;
        logic [DATA_W-1:0] r_s1_data;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1_valid <= 1'b0;
                r_s1_err   <= 1'b0;
                r_s1_data  <= '0;
                r_rd_valid <= 1'b0;
                r_rd_err   <= 1'b0;
                r_rd_data  <= '0;
            end else begin
                r_s1_valid <= w_rd_go;
                r_s1_err   <= w_rd_bad;
                if (w_rd_go) begin
                    r_s1_data <= w_rd_word;
                end
                r_rd_valid <= r_s1_valid;
                r_rd_err   <= r_s1_err;
                if (r_s1_valid) begin
                    r_rd_data <= r_s1_data;
                end
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_valid <= 1'b0;
                r_rd_err   <= 1'b0;
                r_rd_data  <= '0;
            end else begin
                r_rd_valid <= w_rd_go;
                r_rd_err   <= w_rd_bad;
                if (w_rd_go) begin
                    r_rd_data <= w_rd_word;
                end
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign rd_err    = r_rd_err;
    assign wr_err    = r_wr_err;
    assign init_busy = w_init_busy;

endmodule : ram_dp_param
`default_nettype wire

// File: tb/tb_ram_dp_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_dp_param
// Purpose  : Scoreboard bench for ram_dp_param. Two instances share one
//            stimulus stream:
//              A: DEPTH=16, RD_LAT=1, READ_FIRST
//              B: DEPTH=12, RD_LAT=2, WRITE_FIRST
//            Each read request pushes the hand-computed response of each
//            instance into its own queue; per-instance monitors pop and
//            compare data, error flag and arrival cycle whenever rd_valid
//            is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_dp_param;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_enb = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        rd_enb = 1'b0;
    logic [3:0]  rd_addr = '0;

    logic [31:0] a_rd_data, b_rd_data;
    logic        a_rd_valid, b_rd_valid;
    logic        a_wr_err, b_wr_err;
    logic        a_rd_err, b_rd_err;
    logic        a_init_busy, b_init_busy;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_dp_param #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_LAT(1), .COLLISION(0)) u_dut_a (
        .clk(clk), .rst(rst),
        .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_enb(rd_enb), .rd_addr(rd_addr),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .wr_err(a_wr_err), .rd_err(a_rd_err), .init_busy(a_init_busy)
    );

    ram_dp_param #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .RD_LAT(2), .COLLISION(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_enb(rd_enb), .rd_addr(rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .wr_err(b_wr_err), .rd_err(b_rd_err), .init_busy(b_init_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_rd_valid === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_rd_valid", 32'd1, 32'd0);
            end else begin
                e = qa.pop_front();
                chk("a_rd_data", a_rd_data, e.data);
                chk("a_rd_err", {31'd0, a_rd_err}, {31'd0, e.err});
                chk("a_rd_latency_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_rd_valid === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_rd_valid", 32'd1, 32'd0);
            end else begin
                e = qb.pop_front();
                chk("b_rd_data", b_rd_data, e.data);
                chk("b_rd_err", {31'd0, b_rd_err}, {31'd0, e.err});
                chk("b_rd_latency_cycle", cyc, e.cyc);
            end
        end
    end

    // ---------------- stimulus helpers (called at negedge) ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic push_exp(input logic [31:0] da, input logic ea, input bit pa,
                            input logic [31:0] db, input logic eb, input bit pb);
        if (pa) qa.push_back('{data: da, err: ea, cyc: cyc + 1});
        if (pb) qb.push_back('{data: db, err: eb, cyc: cyc + 2});
    endtask

    task automatic rd(input logic [3:0] a,
                      input logic [31:0] da, input logic ea, input bit pa,
                      input logic [31:0] db, input logic eb, input bit pb);
        rd_enb  = 1'b1;
        rd_addr = a;
        push_exp(da, ea, pa, db, eb, pb);
        @(negedge clk);
        rd_enb = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_enb  = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
        @(negedge clk);
        wr_enb = 1'b0;
    endtask

    task automatic wr_rd(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be,
                         input logic [31:0] da, input logic [31:0] db);
        wr_enb  = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
        rd_enb  = 1'b1;
        rd_addr = a;
        push_exp(da, 1'b0, 1'b1, db, 1'b0, 1'b1);
        @(negedge clk);
        wr_enb = 1'b0;
        rd_enb = 1'b0;
    endtask

    // Contents of words 0..11 after the collision tests (same in both).
    function automatic logic [31:0] mid_val(input int a);
        case (a)
            3:       return 32'hAA22CC44;
            5:       return 32'hDEADBEEF;
            6:       return 32'h00005678;
            default: return 32'h0;
        endcase
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int a_busy, b_busy;
        logic a_junk, b_junk;

        // Reset state
        tick(2);
        chk("a_reset_init_busy", {31'd0, a_init_busy}, 32'd1);
        chk("b_reset_init_busy", {31'd0, b_init_busy}, 32'd1);
        chk("a_reset_rd_valid", {31'd0, a_rd_valid}, 32'd0);
        chk("b_reset_rd_valid", {31'd0, b_rd_valid}, 32'd0);
        chk("a_reset_rd_data", a_rd_data, 32'd0);
        chk("b_reset_rd_data", b_rd_data, 32'd0);
        chk("b_reset_errs", {30'd0, b_wr_err, b_rd_err}, 32'd0);

        // Init: count busy cycles while hammering ignored requests at addr 2
        rst = 1'b0;
        a_busy = 0;
        b_busy = 0;
        a_junk = 1'b0;
        b_junk = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (a_init_busy) a_busy++;
            if (b_init_busy) b_busy++;
            a_junk |= a_wr_err | a_rd_err | a_rd_valid;
            b_junk |= b_wr_err | b_rd_err | b_rd_valid;
            rd_enb  = (k < 10);
            wr_enb  = (k < 10);
            rd_addr = 4'd2;
            wr_addr = 4'd2;
            wr_data = 32'hFFFFFFFF;
            wr_be   = 4'hF;
            @(negedge clk);
        end
        rd_enb = 1'b0;
        wr_enb = 1'b0;
        chk("a_init_busy_cycles", a_busy, 16);
        chk("b_init_busy_cycles", b_busy, 12);
        chk("a_init_ignores_requests", {31'd0, a_junk}, 32'd0);
        chk("b_init_ignores_requests", {31'd0, b_junk}, 32'd0);

        // All words zero after init; B flags 12..15 as out of range
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), 32'h0, 1'b0, 1'b1, 32'h0, (i >= 12), 1'b1);
        end
        tick(3);

        // Byte-enable merge
        wr(4'd3, 32'hAABBCCDD, 4'b1111);
        wr(4'd3, 32'h11223344, 4'b0101);
        rd(4'd3, 32'hAA22CC44, 1'b0, 1'b1, 32'hAA22CC44, 1'b0, 1'b1);
        tick(3);
        // rd_data holds while idle
        chk("a_rd_data_hold", a_rd_data, 32'hAA22CC44);
        chk("b_rd_data_hold", b_rd_data, 32'hAA22CC44);
        chk("a_idle_rd_valid", {31'd0, a_rd_valid}, 32'd0);

        // Collisions: A read-first, B write-first (with partial merge)
        wr_rd(4'd5, 32'hDEADBEEF, 4'b1111, 32'h00000000, 32'hDEADBEEF);
        rd(4'd5, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
        wr_rd(4'd6, 32'h12345678, 4'b0011, 32'h00000000, 32'h00005678);
        rd(4'd6, 32'h00005678, 1'b0, 1'b1, 32'h00005678, 1'b0, 1'b1);
        tick(3);

        // Range errors: addr 13 is legal for A, illegal for B
        wr(4'd13, 32'h55555555, 4'hF);
        chk("a_wr_err_in_range", {31'd0, a_wr_err}, 32'd0);
        chk("b_wr_err_pulse", {31'd0, b_wr_err}, 32'd1);
        tick(1);
        chk("b_wr_err_one_cycle", {31'd0, b_wr_err}, 32'd0);
        rd(4'd13, 32'h55555555, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
        rd(4'd14, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            rd(4'(i), mid_val(i), 1'b0, 1'b1, mid_val(i), 1'b0, 1'b1);
        end
        tick(3);

        // Streaming: preload i+0x100, read 0..7 back to back
        for (int i = 0; i < 8; i++) begin
            wr(4'(i), 32'h100 + i, 4'hF);
        end
        for (int i = 0; i < 8; i++) begin
            rd(4'(i), 32'h100 + i, 1'b0, 1'b1, 32'h100 + i, 1'b0, 1'b1);
        end
        tick(3);

        // Write landing while a read is in flight does not alter it
        rd(4'd7, 32'h107, 1'b0, 1'b1, 32'h107, 1'b0, 1'b1);
        wr(4'd7, 32'hCAFEF00D, 4'hF);
        tick(2);
        rd(4'd7, 32'hCAFEF00D, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
        tick(3);

        // Reset mid-stream: B's second read is still in its pipeline
        rd(4'd0, 32'h100, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
        rd(4'd1, 32'h101, 1'b0, 1'b1, 32'h101, 1'b0, 1'b0);
        rst = 1'b1;
        tick(1);
        chk("a_rst_rd_valid", {31'd0, a_rd_valid}, 32'd0);
        chk("b_rst_rd_valid_flush", {31'd0, b_rd_valid}, 32'd0);
        chk("a_rst_init_busy", {31'd0, a_init_busy}, 32'd1);
        chk("b_rst_init_busy", {31'd0, b_init_busy}, 32'd1);
        tick(1);
        rst = 1'b0;
        tick(20);
        chk("a_reinit_done", {31'd0, a_init_busy}, 32'd0);
        rd(4'd3, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        rd(4'd7, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        rd(4'd13, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
        tick(4);

        chk("a_scoreboard_drained", qa.size(), 32'd0);
        chk("b_scoreboard_drained", qb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ram_dp_param
`default_nettype wire
